// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - read-side drain engine for the async FIFO
// Issues FIFO reads, buffers returned words in a small queue and streams them out.

module fifo_rd_drain #(
   parameter int WIDTH     = 8,
   parameter int BUF_DEPTH = 4,
   parameter int CNT_W     = 16
) (
   input  logic             rd_clk,
   input  logic             rst,
   input  logic             drain_en,
   input  logic             empty,
   input  logic             underflow,
   input  logic [WIDTH-1:0] rdata,
   output logic             rd_en,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] rd_count,
   output logic             err_underflow,
   input  logic             err_clr
);

   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = $clog2(BUF_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t           state;
   logic [WIDTH-1:0] mem [BUF_DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [CW-1:0]    count;
   logic             inflight;
   logic [CW:0]      occupancy;
   logic             push;
   logic             pop;

   // A read in flight already owns a queue slot, so it counts toward occupancy.
   assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign rd_en     = (state == RUN) && !empty && (occupancy < (CW+1)'(BUF_DEPTH)) && !rst;
   assign push      = inflight && !underflow;
   assign pop       = (count != '0) && out_ready;
   assign out_valid = (count != '0);
   assign out_data  = mem[head];
   assign busy      = (state != IDLE);

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge rd_clk) begin
      if (rst) begin
         state         <= IDLE;
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         inflight      <= 1'b0;
         rd_count      <= '0;
         err_underflow <= 1'b0;
         done          <= 1'b0;
         for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      end else begin
         inflight <= rd_en;
         if (push) begin
            mem[tail] <= rdata;
            tail      <= ptr_next(tail);
            rd_count  <= rd_count + 1'b1;
         end
         if (pop) head <= ptr_next(head);
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;

         // Set has priority over clear so an underflow is never missed.
         if (underflow)    err_underflow <= 1'b1;
         else if (err_clr) err_underflow <= 1'b0;

         done <= 1'b0;
         case (state)
            IDLE:    if (drain_en) state <= RUN;
            RUN:     if (!drain_en) state <= DRAIN;
            DRAIN: begin
               if (drain_en) state <= RUN;
               else if ((count == '0) && !inflight) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_no_push_full: assert property (@(posedge rd_clk) disable iff (rst)
      !(push && (count == CW'(BUF_DEPTH))));

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb/tb_fifo_rd_drain.sv - randomized bench for fifo_rd_drain against a queue-based model

module tb_fifo_rd_drain;

   localparam int WIDTH     = 8;
   localparam int BUF_DEPTH = 4;
   localparam int CNT_W     = 4;

   logic             rd_clk = 1'b0;
   logic             rst, drain_en, empty, underflow, out_ready, err_clr;
   logic [WIDTH-1:0] rdata;
   logic             rd_en, out_valid, busy, done, err_underflow;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] rd_count;

   always #5 rd_clk = ~rd_clk;

   fifo_rd_drain #(.WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) dut (
      .rd_clk(rd_clk), .rst(rst), .drain_en(drain_en), .empty(empty),
      .underflow(underflow), .rdata(rdata), .rd_en(rd_en), .out_valid(out_valid),
      .out_data(out_data), .out_ready(out_ready), .busy(busy), .done(done),
      .rd_count(rd_count), .err_underflow(err_underflow), .err_clr(err_clr)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: the source FIFO, the word buffer and the control state.
   logic [WIDTH-1:0] fifo_q[$];
   logic [WIDTH-1:0] mq[$];
   int               m_state;      // 0 idle, 1 run, 2 drain
   bit               m_inflight;
   logic [WIDTH-1:0] m_word;
   int               m_cnt;
   bit               m_err;
   bit               m_done;
   int               rd_pulses;

   function automatic bit exp_rd_en();
      return !rst && (m_state == 1) && !empty && ((mq.size() + int'(m_inflight)) < BUF_DEPTH);
   endfunction

   task automatic model_reset();
      mq.delete();
      m_state = 0; m_inflight = 0; m_cnt = 0; m_err = 0; m_done = 0;
   endtask

   // Called just after a rising edge with inputs set; checks, advances the model, returns after the next edge.
   task automatic step();
      bit ren, push, pop, dn;
      empty = (fifo_q.size() == 0);
      #4;
      ren = exp_rd_en();
      check("rd_en", rd_en, ren);
      check("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) check("out_data", out_data, mq[0]);
      check("busy", busy, m_state != 0);
      check("done", done, m_done);
      check("rd_count", rd_count, m_cnt);
      check("err_underflow", err_underflow, m_err);
      if (ren) rd_pulses++;
      if (rst) model_reset();
      else begin
         push = m_inflight && !underflow;
         pop  = (mq.size() != 0) && out_ready;
         dn   = (m_state == 2) && !drain_en && (mq.size() == 0) && !m_inflight;
         if (pop) void'(mq.pop_front());
         if (push) begin
            mq.push_back(m_word);
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
         end
         if (underflow)    m_err = 1;
         else if (err_clr) m_err = 0;
         m_done = dn;
         case (m_state)
            0: if (drain_en) m_state = 1;
            1: if (!drain_en) m_state = 2;
            default: if (drain_en) m_state = 1; else if (dn) m_state = 0;
         endcase
         m_inflight = ren;
         if (ren) m_word = fifo_q.pop_front();
      end
      @(posedge rd_clk);
      #1;
      rdata = m_inflight ? m_word : WIDTH'($urandom);
   endtask

   int               d_cnt;
   logic [CNT_W-1:0] cnt_before;
   logic [WIDTH-1:0] next_word;
   bit               seen;

   initial begin
      rst = 1; drain_en = 0; empty = 1; underflow = 0; out_ready = 0; err_clr = 0; rdata = '0;
      model_reset();
      rd_pulses = 0;
      repeat (2) @(posedge rd_clk);
      #1;
      check("reset out_data", out_data, 0);
      step();

      // Three words, continuous accept.
      rst = 0;
      fifo_q = '{8'h11, 8'h22, 8'h33};
      drain_en = 1; out_ready = 1; rd_pulses = 0;
      repeat (8) step();
      check("three rd pulses", rd_pulses, 3);
      check("three rd_count", rd_count, 3);

      // Back-pressure: buffer fills, then releases in order.
      out_ready = 0; rd_pulses = 0;
      for (int i = 0; i < 10; i++) fifo_q.push_back(WIDTH'(8'h40 + i));
      repeat (10) step();
      check("stall rd pulses", rd_pulses, BUF_DEPTH);
      check("stall out_data", out_data, 8'h40);
      out_ready = 1;
      repeat (14) step();
      check("stall flushed", out_valid, 0);
      check("stall rd_count", rd_count, 13);

      // Stop with two queued and one in flight.
      out_ready = 0;
      fifo_q = '{8'hA1, 8'hA2, 8'hA3};
      repeat (3) step();
      drain_en = 0; out_ready = 1; d_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (done) d_cnt++;
      end
      check("drain done pulses", d_cnt, 1);
      check("drain idle busy", busy, 0);

      // Underflow suppression and sticky error.
      drain_en = 1;
      fifo_q.push_back(8'h5A);
      for (int k = 0; k < 10 && !m_inflight; k++) step();
      check("uf inflight wait", m_inflight, 1);
      cnt_before = rd_count;
      underflow = 1;
      step();
      underflow = 0;
      check("uf rd_count", rd_count, cnt_before);
      check("uf err set", err_underflow, 1);
      step();
      check("uf err sticky", err_underflow, 1);
      err_clr = 1; underflow = 1;
      step();
      underflow = 0;
      check("uf set wins", err_underflow, 1);
      step();
      err_clr = 0;
      check("uf cleared", err_underflow, 0);

      // Randomized traffic.
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(19) == 0) drain_en = ~drain_en;
         out_ready = ($urandom_range(3) != 0);
         underflow = ($urandom_range(39) == 0);
         err_clr   = ($urandom_range(9) == 0);
         rst       = ($urandom_range(199) == 0);
         if ($urandom_range(2) != 0 && fifo_q.size() < 20) fifo_q.push_back(WIDTH'($urandom));
         step();
      end
      underflow = 0; err_clr = 0;

      // Mid-stream reset, resume and count wrap.
      rst = 1;
      step();
      rst = 0; drain_en = 1; out_ready = 0;
      fifo_q.delete();
      for (int i = 0; i < 6; i++) fifo_q.push_back(WIDTH'(8'hC0 + i));
      repeat (5) step();
      rst = 1;
      step();
      rst = 0;
      check("rst out_valid", out_valid, 0);
      check("rst rd_en", rd_en, 0);
      check("rst busy", busy, 0);
      check("rst rd_count", rd_count, 0);
      next_word = fifo_q[0];
      while (fifo_q.size() < 17) fifo_q.push_back(WIDTH'($urandom));
      out_ready = 1; seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (!seen && out_valid) begin
            check("resume word", out_data, next_word);
            seen = 1;
         end
         step();
      end
      check("resume seen", seen, 1);
      check("wrap rd_count", rd_count, 1);

      // Final quiesce.
      drain_en = 0;
      for (int k = 0; k < 50 && busy; k++) step();
      check("final idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
- Read-side consumer for the async FIFO; lives entirely in the read clock domain.
- Drives rd_en against empty, captures rdata one cycle after each read and buffers it in a small internal queue.
- Presents captured words downstream on a valid/ready stream.
- Counts drained words, flags underflow, and sequences a clean stop (IDLE/RUN/DRAIN) so software can quiesce the read path.

Parameters:
- WIDTH, 8, data word width; must match the FIFO width.
- BUF_DEPTH, 4, internal queue entries; legal range 2..16; 3 or more gives one word per cycle.
- CNT_W, 16, width of rd_count.

Ports:
- rd_clk  in  1  read-domain clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- drain_en  in  1  level; 1 = keep reading, 0 = stop and flush
- empty  in  1  FIFO empty flag
- underflow  in  1  FIFO underflow flag
- rdata  in  WIDTH  FIFO read data, valid the cycle after rd_en
- rd_en  out  1  FIFO read strobe
- out_valid  out  1  downstream data valid
- out_data  out  WIDTH  downstream data
- out_ready  in  1  downstream accept
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on DRAIN->IDLE
- rd_count  out  CNT_W  words pushed into the queue, wraps
- err_underflow  out  1  sticky error flag
- err_clr  in  1  clears err_underflow

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; queue count, head and tail = 0; inflight=0; rd_count=0; err_underflow=0.
  - Outputs: rd_en=0, out_valid=0, out_data=0, busy=0, done=0.
  - A mid-operation reset discards queued and in-flight words; the FIFO read the same cycle is lost.
- rd_en is combinational: (state==RUN) && !empty && (count+inflight < BUF_DEPTH) && !rst.
  - It has no path from out_ready.
- inflight register <= rd_en each cycle.
  - When inflight=1, rdata is pushed at the queue tail that edge, unless underflow=1 that cycle.
  - A word suppressed by underflow is not counted.
- Read latency:
  - rd_en high at edge N: word is in the queue after edge N+1.
  - out_valid rises in cycle N+1 after that edge, so earliest out_valid is 2 cycles after rd_en.
  - Back-to-back reads are legal. empty reflects the post-read state next cycle, so reading the last word never underflows.
- Queue:
  - Circular buffer, BUF_DEPTH entries.
  - out_valid = (count != 0); out_data = entry at head, registered storage.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo BUF_DEPTH.
  - Push into a full queue cannot occur by construction; an assertion checks this.
- out_data holds its value while out_valid && !out_ready (stable-until-accepted rule).
- FSM:
  - IDLE -> RUN when drain_en=1.
  - RUN -> DRAIN when drain_en=0. No new rd_en from that cycle on.
  - DRAIN -> RUN when drain_en=1, even if not yet flushed.
  - DRAIN -> IDLE when count==0 && inflight==0 and drain_en=0. done=1 for the first IDLE cycle.
  - IDLE with drain_en=0 stays IDLE, no done.
- rd_count: +1 per pushed word, wraps 2^CNT_W-1 -> 0.
- err_underflow:
  - Set when underflow=1 on any cycle.
  - Cleared by err_clr; set wins if both occur the same cycle.
- empty and underflow are assumed synchronous to rd_clk; no synchronisers inside.

Test Plan:
- Reset, then drain_en=1 with FIFO holding 0x11,0x22,0x33 and out_ready=1 -> rd_en high 3 consecutive cycles; out_data 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after first rd_en; rd_count=3; empty never read.
- BUF_DEPTH=4, out_ready=0, FIFO holds 10 words -> exactly 4 rd_en pulses, then rd_en=0; out_data frozen at word0. Raise out_ready -> remaining 6 words delivered in order, no loss or duplicate.
- drain_en 1->0 with 2 words queued and 1 in flight, out_ready=1 -> no further rd_en; 3 words delivered; done pulses once as state enters IDLE; busy falls the same cycle.
- Force underflow=1 for one cycle while inflight=1 -> word not pushed; rd_count unchanged; err_underflow=1 and sticky. err_clr and underflow together -> stays 1. err_clr alone -> 0.
- CNT_W=4, drain 17 words -> rd_count reads 1 after wrap.
- Assert rst mid-stream with 3 words queued -> next cycle out_valid=0, rd_en=0, busy=0, rd_count=0; after release with drain_en=1, reading resumes from the next FIFO word.
